// File: rtl/glitc_conf_serializer.sv
// Slave-serial configuration engine for the four GLITC FPGAs: WISHBONE-fed word FIFO shifted MSB-first on DIN/CCLK.
// Optional build macro GLITC_CONF_BYTESWAP_EN byte-reverses each word as it is loaded into the shifter.
module glitc_conf_serializer #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CCLK_HALF       = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [3:0]  INIT_B,
    input  logic [3:0]  DONE,
    output logic [3:0]  CCLK,
    output logic [3:0]  DIN
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int HW    = (CCLK_HALF > 1) ? $clog2(CCLK_HALF) : 1;
    localparam logic [HW-1:0] HLAST = HW'(CCLK_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_LOW  = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    function automatic logic [31:0] load_word(input logic [31:0] w);
`ifdef GLITC_CONF_BYTESWAP_EN
        load_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        load_word = w;
`endif
    endfunction

    logic [3:0]                 init_s1_q, init_s2_q, done_s1_q, done_s2_q;
    logic [1:0]                 sel_q;
    logic                       en_q, crc_err_q;
    logic [31:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    state_t                     state_q, state_d;
    logic [HW-1:0]              hcnt_q, hcnt_d;
    logic [4:0]                 bitcnt_q, bitcnt_d;
    logic [31:0]                shift_q, shift_d;
    logic [3:0]                 cclk_d, din_d;

    logic wb_s, wr_fifo_s, wr_ctrl_s, full_s, empty_s, pop_s, stall_s, push_s;
    logic flush_s, abort_s, start_s, busy_s;
    logic [31:0] fifo_head_s;

    assign wb_s        = cyc_i & stb_i;
    assign wr_fifo_s   = wb_s & we_i & (adr_i == 4'd0);
    assign wr_ctrl_s   = wb_s & we_i & (adr_i == 4'd1);
    assign full_s      = (count_q == CW'(DEPTH));
    assign empty_s     = (count_q == CW'(0));
    assign pop_s       = (state_q == S_LOAD) & ~empty_s;
    // A full FIFO still accepts a push on the cycle a pop frees its slot.
    assign stall_s     = wr_fifo_s & full_s & ~pop_s & ~crc_err_q;
    assign ack_o       = wb_s & ~stall_s;
    assign push_s      = wr_fifo_s & ~stall_s & ~crc_err_q;
    assign busy_s      = (state_q != S_IDLE);
    assign abort_s     = busy_s & ~init_s2_q[sel_q];
    assign flush_s     = (wr_ctrl_s & dat_i[5]) | abort_s;
    assign start_s     = en_q & ~crc_err_q & ~empty_s & init_s2_q[sel_q];
    assign fifo_head_s = mem_q[rd_ptr_q];

    // Two-flop synchronisers for the asynchronous GLITC status pins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            init_s1_q <= 4'd0;
            init_s2_q <= 4'd0;
            done_s1_q <= 4'd0;
            done_s2_q <= 4'd0;
        end else begin
            init_s1_q <= INIT_B;
            init_s2_q <= init_s1_q;
            done_s1_q <= DONE;
            done_s2_q <= done_s1_q;
        end
    end

    // Control register: sel only moves while idle; an abort beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                if (state_q == S_IDLE) begin
                    sel_q <= dat_i[1:0];
                end
                en_q <= dat_i[4];
            end
            if (abort_s) begin
                crc_err_q <= 1'b1;
            end else if (wr_ctrl_s && dat_i[6]) begin
                crc_err_q <= 1'b0;
            end
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CW'(0);
        end else if (flush_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Shift FSM next state plus registered CCLK/DIN values.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        case (state_q)
            S_IDLE: begin
                hcnt_d = HW'(0);
                if (start_s) state_d = S_LOAD;
                else         state_d = S_IDLE;
            end
            S_LOAD: begin
                hcnt_d = HW'(0);
                if (!empty_s) begin
                    shift_d  = load_word(fifo_head_s);
                    bitcnt_d = 5'd31;
                    state_d  = S_LOW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOW: begin
                if (hcnt_q == HLAST) begin
                    hcnt_d  = HW'(0);
                    state_d = S_HIGH;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_HIGH: begin
                if (hcnt_q == HLAST) begin
                    hcnt_d = HW'(0);
                    if (bitcnt_q != 5'd0) begin
                        shift_d  = {shift_q[30:0], 1'b0};
                        bitcnt_d = bitcnt_q - 5'd1;
                        state_d  = S_LOW;
                    end else if (en_q && !empty_s) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_s) begin
            state_d = S_IDLE;
            hcnt_d  = HW'(0);
        end else begin
            hcnt_d = hcnt_d;
        end
        cclk_d = 4'd0;
        din_d  = 4'd0;
        if ((state_d == S_LOW) || (state_d == S_HIGH)) din_d[sel_q] = shift_d[31];
        else                                            din_d = 4'd0;
        if (state_d == S_HIGH) cclk_d[sel_q] = 1'b1;
        else                   cclk_d = 4'd0;
    end

    // FSM state and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            hcnt_q   <= HW'(0);
            bitcnt_q <= 5'd0;
            shift_q  <= 32'd0;
            CCLK     <= 4'd0;
            DIN      <= 4'd0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            CCLK     <= cclk_d;
            DIN      <= din_d;
        end
    end

    // Read mux.
    always_comb begin
        dat_o = 32'd0;
        if (adr_i == 4'd1) begin
            dat_o = {init_s2_q, done_s2_q, 8'(count_q), 6'd0, crc_err_q, busy_s,
                     3'd0, en_q, 2'd0, sel_q};
        end else begin
            dat_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_glitc_conf_serializer.sv
// Directed bench for glitc_conf_serializer: a word/bit-queue model checks every CCLK rise,
// plus literal checks of latency, status fields, stalls, abort and reset.
module tb_glitc_conf_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [3:0]  init_b, done;
    logic [3:0]  cclk, din;

    glitc_conf_serializer #(.FIFO_DEPTH_LOG2(4), .CCLK_HALF(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o), .ack_o(ack_o),
        .INIT_B(init_b), .DONE(done), .CCLK(cclk), .DIN(din)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] exp_words[$];
    bit          cur_bits[$];
    int          model_sel = 0;
    bit          hold = 1'b0;
    time         last_rise_t = 0, first_rise_t = 0, ack_t = 0;
    bit          first_rise_seen = 1'b0;
    logic [31:0] obs_word = 32'd0;
    int          rise_cnt = 0;
    logic [3:0]  prev_cclk = 4'd0;
    logic [3:0]  msk;
    logic [31:0] mw;
    bit          mb;

    function automatic logic [31:0] model_load(input logic [31:0] w);
`ifdef GLITC_CONF_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model: idle lines quiet, each CCLK rise carries the next bit.
    always @(negedge clk) begin
        if (rst_n) begin
            msk = 4'b0001 << model_sel;
            chk("unselected_lines", {cclk & ~msk, din & ~msk}, 64'h0);
            if (cclk[model_sel] && !prev_cclk[model_sel]) begin
                rise_cnt++;
                if (!first_rise_seen) begin
                    first_rise_t    = $time;
                    first_rise_seen = 1'b1;
                end
                if (!hold) begin
                    if (cur_bits.size() > 0) begin
                        chk("cclk_period", $time - last_rise_t, 64'd40);
                    end else if (exp_words.size() > 0) begin
                        mw = exp_words.pop_front();
                        for (int i = 31; i >= 0; i--) cur_bits.push_back(mw[i]);
                    end
                    if (cur_bits.size() == 0) begin
                        chk("extra_pulse", 64'd1, 64'd0);
                    end else begin
                        mb = cur_bits.pop_front();
                        chk("din_bit", din[model_sel], mb);
                    end
                    obs_word = {obs_word[30:0], din[model_sel]};
                end
                last_rise_t = $time;
            end
            prev_cclk = cclk;
        end else begin
            prev_cclk = 4'd0;
        end
    end

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input int bound, output bit got);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        got = 1'b0;
        for (int n = 0; n < bound; n++) begin
            #1;
            if (ack_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            ack_t = $time;
        end
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        #1;
        d = dat_o;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input bit kept);
        bit got;
        wb_write(4'd0, w, 50, got);
        chk("push_ack", got, 1'b1);
        if (got && kept) exp_words.push_back(model_load(w));
    endtask

    task automatic ctrl(input logic [1:0] s, input bit en, input bit fl, input bit clr);
        bit got;
        wb_write(4'd1, {25'd0, clr, fl, en, 2'b00, s}, 4, got);
        chk("ctrl_ack", got, 1'b1);
    endtask

    task automatic wait_rises(input int n, input int bound);
        int tgt;
        int c;
        tgt = rise_cnt + n;
        c = 0;
        while (rise_cnt < tgt && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("rises_in_time", rise_cnt >= tgt, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        repeat (3) @(posedge clk);
        for (int n = 0; n < bound; n++) begin
            wb_read(4'd1, d);
            if (!d[8]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] w1;
        bit got;
        int r0;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'd0; dat_w = 32'd0;
        init_b = 4'hF; done = 4'b0101;
        #1;
        chk("rst_cclk_din", {cclk, din}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wb_read(4'd1, d);
        chk("rst_status", d[23:0], 24'h0);
        repeat (3) @(negedge clk);
        wb_read(4'd1, d);
        chk("synced_pins", d[31:24], 8'hF5);

        // Test 1 / 5: one word on GLITC C; byteswap build pushes the swapped image.
`ifdef GLITC_CONF_BYTESWAP_EN
        w1 = 32'h665599AA;
`else
        w1 = 32'hAA995566;
`endif
        ctrl(2'd2, 1'b1, 1'b0, 1'b0);
        model_sel = 2;
        first_rise_seen = 1'b0;
        push(w1, 1'b1);
        wait_rises(32, 200);
        wait_idle(20);
        chk("t1_din_word", obs_word, 32'hAA995566);
        chk("t1_first_rise_latency", first_rise_t - 64'd5 - ack_t, 64'd40);
        chk("t1_model_drained", cur_bits.size() + exp_words.size(), 64'd0);
        wb_read(4'd1, d);
        chk("t1_status", d[23:0], 24'h000012);
        chk("t1_cclk_idle", cclk, 4'h0);

        // Test 2: fill with en=0, 17th write stalls until the first pop.
        ctrl(2'd0, 1'b0, 1'b0, 1'b0);
        model_sel = 0;
        for (int i = 0; i < 16; i++) push(32'h5A5A0000 ^ (i * 32'h01010101), 1'b1);
        wb_read(4'd1, d);
        chk("t2_count_full", d[23:16], 8'd16);
        wb_write(4'd0, 32'hC0FFEE17, 10, got);
        chk("t2_full_stall", got, 1'b0);
        wb_read(4'd1, d);
        chk("t2_count_still_full", d[23:16], 8'd16);
        ctrl(2'd0, 1'b1, 1'b0, 1'b0);
        push(32'hC0FFEE17, 1'b1);
        wb_read(4'd1, d);
        chk("t2_count_after_push", d[23:16], 8'd16);
        wait_idle(2400);
        chk("t2_model_drained", cur_bits.size() + exp_words.size(), 64'd0);
        wb_read(4'd1, d);
        chk("t2_count_empty", d[23:16], 8'd0);

        // Test 3: INIT_B low mid-word aborts, flushes and blocks pushes until cleared.
        ctrl(2'd1, 1'b1, 1'b0, 1'b0);
        model_sel = 1;
        push(32'h12345678, 1'b1);
        push(32'h9ABCDEF0, 1'b1);
        wait_rises(5, 100);
        @(negedge clk);
        hold = 1'b1;
        init_b[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_abort_lines", {cclk, din}, 8'h00);
        exp_words.delete();
        cur_bits.delete();
        hold = 1'b0;
        wb_read(4'd1, d);
        chk("t3_crc_err_set", d[9], 1'b1);
        chk("t3_flushed", d[23:16], 8'd0);
        push(32'hDEADBEEF, 1'b0);
        wb_read(4'd1, d);
        chk("t3_push_dropped", d[23:16], 8'd0);
        init_b[1] = 1'b1;
        r0 = rise_cnt;
        repeat (10) @(negedge clk);
        chk("t3_no_shift", rise_cnt - r0, 64'd0);
        ctrl(2'd1, 1'b1, 1'b0, 1'b1);
        wb_read(4'd1, d);
        chk("t3_crc_cleared", {d[9], d[8]}, 2'b00);

        // Test 4: en=0 at bit 10 finishes the word and leaves two queued.
        ctrl(2'd3, 1'b0, 1'b0, 1'b0);
        model_sel = 3;
        push(32'hF00F0FF0, 1'b1);
        push(32'h0F0F0F0F, 1'b1);
        push(32'h80000001, 1'b1);
        ctrl(2'd3, 1'b1, 1'b0, 1'b0);
        wait_rises(10, 100);
        ctrl(2'd0, 1'b0, 1'b0, 1'b0);
        wait_idle(200);
        chk("t4_word_complete", cur_bits.size(), 64'd0);
        wb_read(4'd1, d);
        chk("t4_status", d[23:0], 24'h020003);
        chk("t4_model_count", d[23:16], exp_words.size());
        ctrl(2'd3, 1'b0, 1'b1, 1'b0);
        exp_words.delete();
        wb_read(4'd1, d);
        chk("t4_flush", d[23:16], 8'd0);

        // Test 6: reset mid-shift clears the lines asynchronously.
        ctrl(2'd3, 1'b1, 1'b0, 1'b0);
        push(32'h13579BDF, 1'b1);
        wait_rises(5, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_lines", {cclk, din}, 8'h00);
        exp_words.delete();
        cur_bits.delete();
        model_sel = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_read(4'd1, d);
        chk("t6_status", d[23:0], 24'h0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
